instr_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the instruction decoder in the multicycle RV32 core.
- Owns the program counter, issues word reads to instruction memory over a ready/valid handshake, and latches the returned word into the instruction register.
- The instruction register drives `instr[31:7]` into the decoder and `instr[6:0]` into the control FSM.
- Detects misaligned fetches, bus errors and memory timeouts, and holds a sticky fault for the control FSM.

---
 rtl/instr_fetch_unit.sv | 154 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage of the multicycle RV32 core: owns the PC, fetches words over a
// ready/valid handshake into the instruction register and reports sticky faults.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic        pc_we,
    input  logic [31:0] pc_next,
    input  logic        fault_clear,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err,
    output logic [31:0] pc,
    output logic [31:0] old_pc,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        fetch_busy,
    output logic        fault,
    output logic [1:0]  fault_cause
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [31:0] NOP          = 32'h0000_0013;
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    localparam logic [1:0] CAUSE_NONE      = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN  = 2'b01;
    localparam logic [1:0] CAUSE_BUS_ERR   = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT   = 2'b11;

    state_t      state;
    state_t      next_state;
    logic [1:0]  cause_next;
    logic [15:0] wait_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The timeout fires on the TIMEOUT-th ready-less cycle; ready takes priority.
    always_comb begin
        next_state = state;
        cause_next = CAUSE_NONE;
        case (state)
            IDLE: begin
                if (fetch_req) begin
                    if (pc[1:0] != 2'b00) begin
                        next_state = FAULT;
                        cause_next = CAUSE_MISALIGN;
                    end else begin
                        next_state = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_ready) begin
                    if (mem_err) begin
                        next_state = FAULT;
                        cause_next = CAUSE_BUS_ERR;
                    end else begin
                        next_state = IDLE;
                    end
                end else if (wait_cnt == TIMEOUT_LAST) begin
                    next_state = FAULT;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            FAULT: begin
                if (fault_clear) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        mem_req    = 1'b0;
        fetch_busy = 1'b0;
        if (state == REQ) begin
            mem_req    = 1'b1;
            fetch_busy = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            mem_addr    <= RESET_PC;
            old_pc      <= 32'h0000_0000;
            instr       <= NOP;
            instr_valid <= 1'b0;
            wait_cnt    <= 16'd0;
        end else begin
            instr_valid <= 1'b0;
            if (pc_we) begin
                pc <= pc_next;
            end
            case (state)
                IDLE: begin
                    if (fetch_req && (pc[1:0] == 2'b00)) begin
                        mem_addr <= pc;
                        wait_cnt <= 16'd0;
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        if (!mem_err) begin
                            instr       <= mem_rdata;
                            old_pc      <= mem_addr;
                            instr_valid <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Cause is latched only on entry to FAULT so it stays put while parked there.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault       <= 1'b0;
            fault_cause <= CAUSE_NONE;
        end else begin
            fault <= (next_state == FAULT);
            if ((state != FAULT) && (next_state == FAULT)) begin
                fault_cause <= cause_next;
            end else if ((state == FAULT) && (next_state == IDLE)) begin
                fault_cause <= CAUSE_NONE;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit (TIMEOUT=4, RESET_PC=0).
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic        fetch_req;
    logic        pc_we;
    logic [31:0] pc_next;
    logic        fault_clear;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_err;
    logic [31:0] pc;
    logic [31:0] old_pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic        fetch_busy;
    logic        fault;
    logic [1:0]  fault_cause;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .TIMEOUT  (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_req   (fetch_req),
        .pc_we       (pc_we),
        .pc_next     (pc_next),
        .fault_clear (fault_clear),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .mem_err     (mem_err),
        .pc          (pc),
        .old_pc      (old_pc),
        .instr       (instr),
        .instr_valid (instr_valid),
        .fetch_busy  (fetch_busy),
        .fault       (fault),
        .fault_cause (fault_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fetch_req   = 1'b0;
        pc_we       = 1'b0;
        pc_next     = 32'h0;
        fault_clear = 1'b0;
        mem_ready   = 1'b0;
        mem_rdata   = 32'h0;
        mem_err     = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #13;
        n_checks++; if (pc !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_pc got %h want %h", pc, 32'h0); end
        n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_mem_addr got %h want %h", mem_addr, 32'h0); end
        n_checks++; if (instr !== 32'h0000_0013) begin n_fail++; $display("[TB] FAIL reset_instr got %h want %h", instr, 32'h13); end
        n_checks++; if ({mem_req, fetch_busy, instr_valid, fault, fault_cause} !== 6'b0) begin n_fail++;
            $display("[TB] FAIL reset_flags got %b want %b", {mem_req, fetch_busy, instr_valid, fault, fault_cause}, 6'b0); end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_zero_wait();
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        n_checks++; if (mem_req !== 1'b1 || fetch_busy !== 1'b1) begin n_fail++;
            $display("[TB] FAIL zw_mem_req got %b/%b want 1/1", mem_req, fetch_busy); end
        n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("[TB] FAIL zw_mem_addr got %h want %h", mem_addr, 32'h0); end
        mem_ready = 1'b1;
        mem_rdata = 32'h0050_0093;
        tick();
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        n_checks++; if (instr !== 32'h0050_0093) begin n_fail++; $display("[TB] FAIL zw_instr got %h want %h", instr, 32'h00500093); end
        n_checks++; if (old_pc !== 32'h0) begin n_fail++; $display("[TB] FAIL zw_old_pc got %h want %h", old_pc, 32'h0); end
        n_checks++; if (instr_valid !== 1'b1 || mem_req !== 1'b0) begin n_fail++;
            $display("[TB] FAIL zw_valid got valid=%b req=%b want 1/0", instr_valid, mem_req); end
        tick();
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL zw_valid_pulse got %b want 0", instr_valid); end
    endtask

    task automatic test_pc_write_during_fetch();
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin n_fail++;
                $display("[TB] FAIL pcw_wait%0d got req=%b addr=%h want 1/%h", i, mem_req, mem_addr, 32'h0); end
            tick();
        end
        mem_ready = 1'b1;
        mem_rdata = 32'h0000_0113;
        pc_we     = 1'b1;
        pc_next   = 32'h4;
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin n_fail++;
            $display("[TB] FAIL pcw_ready_cycle got req=%b addr=%h want 1/%h", mem_req, mem_addr, 32'h0); end
        tick();
        idle_inputs();
        n_checks++; if (instr_valid !== 1'b1 || instr !== 32'h0000_0113) begin n_fail++;
            $display("[TB] FAIL pcw_instr got valid=%b instr=%h want 1/%h", instr_valid, instr, 32'h113); end
        n_checks++; if (pc !== 32'h4 || old_pc !== 32'h0 || mem_addr !== 32'h0) begin n_fail++;
            $display("[TB] FAIL pcw_regs got pc=%h old=%h addr=%h want 4/0/0", pc, old_pc, mem_addr); end
        tick();
    endtask

    task automatic test_misaligned();
        pc_we   = 1'b1;
        pc_next = 32'h0000_0102;
        tick();
        pc_we     = 1'b0;
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        n_checks++; if (fault !== 1'b1 || fault_cause !== 2'b01) begin n_fail++;
            $display("[TB] FAIL mis_fault got %b/%b want 1/01", fault, fault_cause); end
        n_checks++; if (mem_req !== 1'b0 || old_pc !== 32'h0) begin n_fail++;
            $display("[TB] FAIL mis_no_req got req=%b old=%h want 0/%h", mem_req, old_pc, 32'h0); end
        tick();
        n_checks++; if (mem_req !== 1'b0 || fault !== 1'b1) begin n_fail++;
            $display("[TB] FAIL mis_held got req=%b fault=%b want 0/1", mem_req, fault); end
        fault_clear = 1'b1;
        tick();
        fault_clear = 1'b0;
        n_checks++; if (fault !== 1'b0 || fault_cause !== 2'b00 || instr !== 32'h0000_0113) begin n_fail++;
            $display("[TB] FAIL mis_clear got fault=%b cause=%b instr=%h want 0/00/%h", fault, fault_cause, instr, 32'h113); end
        pc_we   = 1'b1;
        pc_next = 32'h8;
        tick();
        pc_we = 1'b0;
    endtask

    task automatic test_timeout();
        int req_cycles;
        req_cycles = 0;
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        n_checks++; if (mem_addr !== 32'h8) begin n_fail++; $display("[TB] FAIL to_mem_addr got %h want %h", mem_addr, 32'h8); end
        for (int i = 0; i < 10; i++) begin
            if (mem_req !== 1'b1) break;
            req_cycles++;
            tick();
        end
        n_checks++; if (req_cycles !== 4) begin n_fail++; $display("[TB] FAIL to_req_cycles got %0d want 4", req_cycles); end
        n_checks++; if (fault !== 1'b1 || fault_cause !== 2'b11) begin n_fail++;
            $display("[TB] FAIL to_cause got %b/%b want 1/11", fault, fault_cause); end
        fault_clear = 1'b1;
        tick();
        fault_clear = 1'b0;
        // Ready on the 4th request cycle is still accepted.
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        tick();
        tick();
        tick();
        mem_ready = 1'b1;
        mem_rdata = 32'h00A0_0113;
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("[TB] FAIL to_4th_req got %b want 1", mem_req); end
        tick();
        idle_inputs();
        n_checks++; if (instr_valid !== 1'b1 || instr !== 32'h00A0_0113 || old_pc !== 32'h8 || fault !== 1'b0) begin n_fail++;
            $display("[TB] FAIL to_4th_ok got valid=%b instr=%h old=%h fault=%b want 1/%h/%h/0",
                     instr_valid, instr, old_pc, fault, 32'h00A00113, 32'h8); end
        tick();
    endtask

    task automatic test_bus_error();
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        mem_ready = 1'b1;
        mem_err   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        tick();
        idle_inputs();
        n_checks++; if (fault !== 1'b1 || fault_cause !== 2'b10 || instr_valid !== 1'b0) begin n_fail++;
            $display("[TB] FAIL be_cause got fault=%b cause=%b valid=%b want 1/10/0", fault, fault_cause, instr_valid); end
        n_checks++; if (instr !== 32'h00A0_0113 || old_pc !== 32'h8) begin n_fail++;
            $display("[TB] FAIL be_kept got instr=%h old=%h want %h/%h", instr, old_pc, 32'h00A00113, 32'h8); end
        fetch_req = 1'b1;
        tick();
        tick();
        fetch_req = 1'b0;
        n_checks++; if (mem_req !== 1'b0 || fault !== 1'b1 || fault_cause !== 2'b10) begin n_fail++;
            $display("[TB] FAIL be_ignore_req got req=%b fault=%b cause=%b want 0/1/10", mem_req, fault, fault_cause); end
        fault_clear = 1'b1;
        tick();
        fault_clear = 1'b0;
    endtask

    task automatic test_back_to_back();
        pc_we   = 1'b1;
        pc_next = 32'h0;
        tick();
        pc_we     = 1'b0;
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'h1111_1093;
        pc_we     = 1'b1;
        pc_next   = 32'h4;
        tick();
        idle_inputs();
        fetch_req = 1'b1;
        n_checks++; if (instr_valid !== 1'b1 || instr !== 32'h1111_1093) begin n_fail++;
            $display("[TB] FAIL b2b_first got valid=%b instr=%h want 1/%h", instr_valid, instr, 32'h11111093); end
        tick();
        fetch_req = 1'b0;
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin n_fail++;
            $display("[TB] FAIL b2b_req got req=%b addr=%h want 1/%h", mem_req, mem_addr, 32'h4); end
        mem_ready = 1'b1;
        mem_rdata = 32'h2222_2113;
        tick();
        idle_inputs();
        n_checks++; if (instr_valid !== 1'b1 || instr !== 32'h2222_2113 || old_pc !== 32'h4) begin n_fail++;
            $display("[TB] FAIL b2b_second got valid=%b instr=%h old=%h want 1/%h/%h", instr_valid, instr, old_pc, 32'h22222113, 32'h4); end
        tick();
    endtask

    task automatic test_async_reset();
        pc_we   = 1'b1;
        pc_next = 32'h20;
        tick();
        pc_we     = 1'b0;
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        tick();
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (mem_req !== 1'b0 || fetch_busy !== 1'b0) begin n_fail++;
            $display("[TB] FAIL ar_req_drop got %b/%b want 0/0", mem_req, fetch_busy); end
        n_checks++; if (pc !== 32'h0 || instr !== 32'h0000_0013 || old_pc !== 32'h0) begin n_fail++;
            $display("[TB] FAIL ar_regs got pc=%h instr=%h old=%h want 0/%h/0", pc, instr, old_pc, 32'h13); end
        tick();
        reset     = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        tick();
        idle_inputs();
        n_checks++; if (instr !== 32'h0000_0013 || instr_valid !== 1'b0 || mem_req !== 1'b0 || fault !== 1'b0) begin n_fail++;
            $display("[TB] FAIL ar_late_ready got instr=%h valid=%b req=%b fault=%b want %h/0/0/0",
                     instr, instr_valid, mem_req, fault, 32'h13); end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_zero_wait();
        test_pc_write_during_fetch();
        test_misaligned();
        test_timeout();
        test_bus_error();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
